tim_capture_seq: RTL and testbench
==================================

# tim_capture_seq

Capture sequencer that drives the vertical timing FSM of the sensor timing chain. It programs the 24-bit shutter time over the FSM's 2-bit address / 8-bit data register bus, then issues trigger pulses. It tracks readout by counting `vact` line pulses and runs a burst of N frames with a programmable inter-frame gap. It sits between the host control register block and the vertical timing FSM, on the 30 MHz PIXCLK domain.

## Interface
- `LINES`, 3324: `vact` rising edges that make up one frame.
- `TRIG_LEN`, 4: trigger pulse width, in clk cycles.
- `TIMEOUT`, 32'd150_000_000: watchdog limit in clk cycles. Used only when the watchdog is compiled in.
- `clk` in 1: PIXCLK, 30 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a burst. Honoured only in IDLE.
- `abort` in 1: level. Stops any activity.
- `shutter` in 24: shutter time in 125 µs units. Latched on an accepted start.
- `frames` in 8: burst length. 0 means continuous until abort. Latched on start.
- `gap` in 16: idle cycles between the end of one frame and the next trigger. Latched on start.
- `vact` in 1: line-active signal from the vertical FSM, synchronous to clk.
- `reg_a` out 2: register address to the vertical FSM.
- `reg_d` out 8: register data to the vertical FSM.
- `reg_we` out 1: register write strobe to the vertical FSM.
- `trigger` out 1: trigger to the vertical FSM.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `frame_idx` out 8: frames completed in the current burst. Wraps 255→0 in continuous mode.
- `error` out 1: sticky watchdog flag.

## Operation
- States: IDLE, CFG1, CFG2, CFG3, TRIG, WAITV, READ, GAP.
- IDLE
  - On `start && !abort`: latch `shutter`, `frames` and `gap`.
  - Clear `frame_idx` and `error`, then go to CFG1.
- CFG1, CFG2, CFG3: write one byte per state, one cycle each, with `reg_we`=1.
  - CFG1: `reg_a`=1, `reg_d`=`shutter[23:16]`.
  - CFG2: `reg_a`=2, `reg_d`=`shutter[15:8]`.
  - CFG3: `reg_a`=3, `reg_d`=`shutter[7:0]`.
  - After CFG3, go to TRIG.
- TRIG: hold `trigger`=1 for exactly `TRIG_LEN` cycles, then go to WAITV.
- WAITV: wait for the first `vact` rising edge, then go to READ. That edge counts as line 1.
- READ
  - Count `vact` rising edges, detected against a registered copy of `vact`.
  - When the count equals `LINES` and `vact` falls: pulse `frame_done` and increment `frame_idx`.
  - If `frames`≠0 and the new `frame_idx` equals `frames`, go to IDLE. Otherwise go to GAP.
- GAP: count `gap` cycles, then go to TRIG. `gap`=0 means direct to TRIG. The shutter registers are not rewritten.
- Abort
  - `abort`=1 in any state: go to IDLE on the next edge, with `trigger` and `reg_we` forced to 0 that same edge.
  - No `frame_done` pulse is issued. `frame_idx` holds its value.
- `start` outside IDLE is ignored. `start` and `abort` asserted together in IDLE: abort wins.
- The line counter is 12 bits and is cleared on entry to WAITV.

## Timing
- All outputs are registered.
- Reset values:
  - `reg_a`=0, `reg_d`=0, `reg_we`=0.
  - `trigger`=0, `busy`=0, `frame_done`=0, `frame_idx`=0, `error`=0.
  - State is IDLE.
- `start` sampled at edge 0:
  - `busy` and the CFG1 write are visible after edge 1.
  - CFG3 completes after edge 3.
  - `trigger` is high after edges 4 through 4+`TRIG_LEN`−1, i.e. 4 cycles by default.
- `frame_done` is asserted in the cycle after the `vact` falling edge is sampled.
- `busy` drops in the same cycle as the final `frame_done`.
- Reset mid-operation takes effect immediately and asynchronously, including during a `reg_we` cycle.

## Configuration
- Macro: `TIM_CAPTURE_SEQ_WATCHDOG_EN`.
- Defined:
  - A 32-bit counter clears on every state change and on every `vact` rising edge.
  - If it reaches `TIMEOUT` in WAITV or READ: set `error`=1 and go to IDLE with no `frame_done`.
  - `error` stays set until the next accepted start or reset.
- Not defined:
  - No counter is present, and WAITV and READ wait indefinitely.
  - `error` is tied to 0.

## Test plan
- Single frame:
  - Stimulus: `shutter`=0x0A0B0C, `frames`=1, `LINES`=4 on the bench, vact model.
  - Response: writes (1,0x0A), (2,0x0B), (3,0x0C) on consecutive cycles, then 4-cycle `trigger`, then one `frame_done`, then `frame_idx`=1 and `busy`=0.
- Burst:
  - Stimulus: `frames`=3, `gap`=10.
  - Response: exactly one register write sequence, three triggers, ≥10 idle cycles between each `frame_done` and the next trigger, final `frame_idx`=3.
- Abort mid-READ after 2 lines:
  - Response: next cycle `busy`=0 and `trigger`=0, no `frame_done`, `frame_idx` unchanged.
- Continuous mode:
  - Stimulus: `frames`=0, run 257 frames.
  - Response: `frame_idx` wraps to 1 and `busy` stays high until abort.
- Start and abort in the same cycle in IDLE:
  - Response: no write and `busy` stays 0. A start while busy does not restart CFG.
- Watchdog:
  - Stimulus: macro defined, `TIMEOUT`=100, `vact` held low.
  - Response: `error`=1 and IDLE 100 cycles after WAITV entry. The next start clears `error`.

Source files
------------

// File: rtl/tim_capture_seq.sv
// -----------------------------------------------------------------------------
// tim_capture_seq
//
// Capture sequencer for the vertical timing FSM on the PIXCLK domain. On an
// accepted start it writes the 24-bit shutter time over the 2-bit address /
// 8-bit data register bus, one byte per cycle (addresses 1..3, MSB first).
// It then runs a burst of frames. Each frame is a TRIG_LEN-cycle trigger
// pulse, followed by LINES vact rising edges, followed by the final vact
// fall. Frames are separated by a programmable gap.
//
// Optional feature (compile-time macro TIM_CAPTURE_SEQ_WATCHDOG_EN):
//   A 32-bit watchdog aborts WAITV/READ after TIMEOUT idle cycles and sets a
//   sticky error flag. Without the macro there is no counter and error is 0.
//
// Parameters
//   LINES     vact rising edges per frame (line counter is 12 bits)
//   TRIG_LEN  trigger pulse width in clk cycles
//   TIMEOUT   watchdog limit in clk cycles (watchdog build only)
//
// Ports
//   clk, rst_n   PIXCLK and asynchronous active-low reset
//   start        one-cycle burst request, honoured only in IDLE
//   abort        level, returns to IDLE from any state (wins over start)
//   shutter      24-bit shutter time, latched on accepted start
//   frames       burst length, 0 = continuous, latched on accepted start
//   gap          idle cycles between frame end and next trigger, latched
//   vact         line-active from the vertical FSM
//   reg_a/reg_d/reg_we  register write bus to the vertical FSM
//   trigger      trigger pulse to the vertical FSM
//   busy         high while a burst is in progress
//   frame_done   one-cycle pulse at the end of each frame
//   frame_idx    frames completed in the current burst (wraps)
//   error        sticky watchdog flag
// -----------------------------------------------------------------------------
module tim_capture_seq #(
  parameter int          LINES    = 3324,
  parameter int          TRIG_LEN = 4,
  parameter logic [31:0] TIMEOUT  = 32'd150_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] shutter,
  input  logic [7:0]  frames,
  input  logic [15:0] gap,
  input  logic        vact,
  output logic [1:0]  reg_a,
  output logic [7:0]  reg_d,
  output logic        reg_we,
  output logic        trigger,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_idx,
  output logic        error
);

  localparam logic [11:0] LINES_C   = 12'(LINES);
  localparam logic [15:0] TRIG_LAST = 16'(TRIG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG1  = 3'd1,
    CFG2  = 3'd2,
    CFG3  = 3'd3,
    TRIG  = 3'd4,
    WAITV = 3'd5,
    READ  = 3'd6,
    GAP   = 3'd7
  } state_t;

  state_t      state;
  state_t      state_n;

  // burst configuration, captured on accepted start only
  logic [23:0] shutter_q;
  logic [7:0]  frames_q;
  logic [15:0] gap_q;

  logic        vact_q;
  logic [15:0] trig_cnt;
  logic [15:0] gap_cnt;
  logic [11:0] line_cnt;

  logic        accept;
  logic        rise;
  logic        fall;
  logic        last_frame;
  logic        frame_end;

`ifdef TIM_CAPTURE_SEQ_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        wd_fire;
  logic        error_q;
`endif

  assign accept     = (state == IDLE) && start && !abort;
  assign rise       = vact && !vact_q;
  assign fall       = !vact && vact_q;
  // frame_idx still holds the pre-increment count here
  assign last_frame = (frames_q != 8'd0) && (8'(frame_idx + 8'd1) == frames_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    frame_end = 1'b0;
`ifdef TIM_CAPTURE_SEQ_WATCHDOG_EN
    wd_fire   = 1'b0;
`endif
    case (state)
      IDLE:  if (start) state_n = CFG1;
      CFG1:  state_n = CFG2;
      CFG2:  state_n = CFG3;
      CFG3:  state_n = TRIG;
      TRIG:  if (trig_cnt == TRIG_LAST) state_n = WAITV;
      WAITV: if (rise) state_n = READ;
      READ: begin
        if (fall && (line_cnt == LINES_C)) begin
          frame_end = 1'b1;
          if (last_frame)          state_n = IDLE;
          else if (gap_q == 16'd0) state_n = TRIG;
          else                     state_n = GAP;
        end
      end
      GAP:   if (gap_cnt == 16'(gap_q - 16'd1)) state_n = TRIG;
      default: state_n = IDLE;
    endcase

`ifdef TIM_CAPTURE_SEQ_WATCHDOG_EN
    // counter value n means n full cycles since the last state change / line
    if (((state == WAITV) || (state == READ)) && (wd_cnt >= 32'(TIMEOUT - 32'd1))) begin
      state_n   = IDLE;
      frame_end = 1'b0;
      wd_fire   = 1'b1;
    end
`endif

    // abort overrides everything, including a frame ending this cycle
    if (abort) begin
      state_n   = IDLE;
      frame_end = 1'b0;
`ifdef TIM_CAPTURE_SEQ_WATCHDOG_EN
      wd_fire   = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vact_q     <= 1'b0;
      trig_cnt   <= 16'd0;
      gap_cnt    <= 16'd0;
      line_cnt   <= 12'd0;
      reg_a      <= 2'd0;
      reg_d      <= 8'd0;
      reg_we     <= 1'b0;
      trigger    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_idx  <= 8'd0;
    end else begin
      state  <= state_n;
      vact_q <= vact;

      // both counters restart from 0 on every entry to their state
      trig_cnt <= (state == TRIG) ? 16'(trig_cnt + 16'd1) : 16'd0;
      gap_cnt  <= (state == GAP)  ? 16'(gap_cnt + 16'd1)  : 16'd0;

      // the rising edge that releases WAITV is line 1
      if ((state_n == WAITV) && (state != WAITV))
        line_cnt <= 12'd0;
      else if ((state == WAITV) && rise)
        line_cnt <= 12'd1;
      else if ((state == READ) && rise)
        line_cnt <= 12'(line_cnt + 12'd1);

      // outputs follow the current state one cycle later, so the CFG1 write
      // appears the cycle after the state register leaves IDLE
      reg_we <= 1'b0;
      reg_a  <= 2'd0;
      reg_d  <= 8'd0;
      if (!abort) begin
        case (state)
          CFG1: begin reg_we <= 1'b1; reg_a <= 2'd1; reg_d <= shutter_q[23:16]; end
          CFG2: begin reg_we <= 1'b1; reg_a <= 2'd2; reg_d <= shutter_q[15:8];  end
          CFG3: begin reg_we <= 1'b1; reg_a <= 2'd3; reg_d <= shutter_q[7:0];   end
          default: ;
        endcase
      end
      trigger <= (state == TRIG) && !abort;

      // looking at state_n lets busy fall together with the last frame_done
      // and immediately on abort, while still rising one cycle after start
      busy <= (state != IDLE) && (state_n != IDLE);

      frame_done <= frame_end;
      if (accept)
        frame_idx <= 8'd0;
      else if (frame_end)
        frame_idx <= 8'(frame_idx + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shutter_q <= shutter;
      frames_q  <= frames;
      gap_q     <= gap;
    end
  end

`ifdef TIM_CAPTURE_SEQ_WATCHDOG_EN
  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= 32'd0;
      error_q <= 1'b0;
    end else begin
      if ((state_n != state) || rise)
        wd_cnt <= 32'd0;
      else if ((state == WAITV) || (state == READ))
        wd_cnt <= 32'(wd_cnt + 32'd1);
      else
        wd_cnt <= 32'd0;

      if (accept)
        error_q <= 1'b0;
      else if (wd_fire)
        error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_tim_capture_seq.sv
// -----------------------------------------------------------------------------
// tb_tim_capture_seq
//
// Directed bench for tim_capture_seq with LINES=4 and TIMEOUT=100. A small
// vact model answers every trigger with a train of line pulses. A negedge
// monitor logs register writes, trigger rises and frame_done pulses. The
// burst table drives whole bursts. Hand-written sequences cover exact
// start timing, abort, continuous mode, the watchdog and async reset.
// -----------------------------------------------------------------------------
module tb_tim_capture_seq;

  localparam int LINES    = 4;
  localparam int TRIG_LEN = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [23:0] shutter;
  logic [7:0]  frames;
  logic [15:0] gap;
  logic        vact;
  logic [1:0]  reg_a;
  logic [7:0]  reg_d;
  logic        reg_we;
  logic        trigger;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_idx;
  logic        error;

  tim_capture_seq #(
    .LINES    (LINES),
    .TRIG_LEN (TRIG_LEN),
    .TIMEOUT  (32'd100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .shutter    (shutter),
    .frames     (frames),
    .gap        (gap),
    .vact       (vact),
    .reg_a      (reg_a),
    .reg_d      (reg_d),
    .reg_we     (reg_we),
    .trigger    (trigger),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_idx  (frame_idx),
    .error      (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // vact model: after a trigger falls, two quiet cycles, then vact_lines
  // pulses of two cycles high / two cycles low
  logic vact_en;
  int   vact_lines;
  logic trig_d;

  initial begin
    vact   = 1'b0;
    trig_d = 1'b0;
    forever begin
      @(negedge clk);
      if (vact_en && trig_d && !trigger) begin
        repeat (2) @(negedge clk);
        for (int l = 0; l < vact_lines; l++) begin
          vact = 1'b1;
          repeat (2) @(negedge clk);
          vact = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
      trig_d = trigger;
    end
  end

  // monitor
  int         we_total   = 0;
  int         trig_total = 0;
  int         fd_total   = 0;
  int         since_fd   = 0;
  int         cyc        = 0;
  logic       trig_m     = 1'b0;
  logic [1:0] wa      [256];
  logic [7:0] wd      [256];
  int         wcyc    [256];
  int         gap_log [256];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    trig_m <= trigger;
    if (reg_we) begin
      wa[we_total % 256]   <= reg_a;
      wd[we_total % 256]   <= reg_d;
      wcyc[we_total % 256] <= cyc;
      we_total             <= we_total + 1;
    end
    if (frame_done) begin
      since_fd <= 0;
      fd_total <= fd_total + 1;
    end else begin
      since_fd <= since_fd + 1;
    end
    if (trigger && !trig_m) begin
      gap_log[trig_total % 256] <= since_fd;
      trig_total                <= trig_total + 1;
    end
  end

  typedef struct {
    logic [23:0] sh;
    logic [7:0]  fr;
    logic [15:0] gp;
    int          exp_we;
    int          exp_trig;
    int          exp_fd;
    logic [7:0]  exp_idx;
  } vec_t;

  vec_t vec [4];

  task automatic wait_busy_low(input string name, input int limit);
    int n;
    n = 0;
    while (busy && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_end_in_time"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_trigger(input logic lvl, input int limit);
    int n;
    n = 0;
    while ((trigger !== lvl) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    chk("trigger_wait", 32'(trigger), 32'(lvl));
  endtask

  int we0;
  int t0;
  int f0;
  int n;
  logic [7:0] byte_exp;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    shutter    = 24'd0;
    frames     = 8'd0;
    gap        = 16'd0;
    vact_en    = 1'b1;
    vact_lines = LINES;

    vec[0] = '{24'h0A0B0C, 8'd1, 16'd0,  3, 1, 1, 8'd1};
    vec[1] = '{24'h123456, 8'd3, 16'd10, 3, 3, 3, 8'd3};
    vec[2] = '{24'hFFFFFF, 8'd2, 16'd0,  3, 2, 2, 8'd2};
    vec[3] = '{24'h800001, 8'd4, 16'd1,  3, 4, 4, 8'd4};

    repeat (3) @(negedge clk);
    chk("rst_reg_a",      32'(reg_a), 32'd0);
    chk("rst_reg_d",      32'(reg_d), 32'd0);
    chk("rst_reg_we",     32'(reg_we), 32'd0);
    chk("rst_trigger",    32'(trigger), 32'd0);
    chk("rst_busy",       32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_idx",  32'(frame_idx), 32'd0);
    chk("rst_error",      32'(error), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // exact timing of a single frame
    shutter = 24'h0A0B0C; frames = 8'd1; gap = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("e0_busy", 32'(busy), 32'd0);
    chk("e0_we",   32'(reg_we), 32'd0);
    @(negedge clk);
    chk("e1_busy", 32'(busy), 32'd1);
    chk("e1_we",   32'(reg_we), 32'd1);
    chk("e1_a",    32'(reg_a), 32'd1);
    chk("e1_d",    32'(reg_d), 32'h0A);
    @(negedge clk);
    chk("e2_we",   32'(reg_we), 32'd1);
    chk("e2_a",    32'(reg_a), 32'd2);
    chk("e2_d",    32'(reg_d), 32'h0B);
    @(negedge clk);
    chk("e3_we",   32'(reg_we), 32'd1);
    chk("e3_a",    32'(reg_a), 32'd3);
    chk("e3_d",    32'(reg_d), 32'h0C);
    for (int i = 0; i < TRIG_LEN; i++) begin
      @(negedge clk);
      chk("trig_on", 32'(trigger), 32'd1);
      chk("trig_we", 32'(reg_we), 32'd0);
    end
    @(negedge clk);
    chk("trig_off", 32'(trigger), 32'd0);
    n = 0;
    while (!frame_done && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk("sf_frame_done", 32'(frame_done), 32'd1);
    chk("sf_busy",       32'(busy), 32'd0);
    chk("sf_frame_idx",  32'(frame_idx), 32'd1);
    @(negedge clk);
    chk("sf_done_pulse", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);

    // burst table
    for (int v = 0; v < 4; v++) begin
      we0 = we_total; t0 = trig_total; f0 = fd_total;
      shutter = vec[v].sh; frames = vec[v].fr; gap = vec[v].gp; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("tbl_busy_up", 32'(busy), 32'd1);
      wait_busy_low("tbl", 5000);
      repeat (2) @(negedge clk);
      chk("tbl_writes",    32'(we_total - we0), 32'(vec[v].exp_we));
      chk("tbl_triggers",  32'(trig_total - t0), 32'(vec[v].exp_trig));
      chk("tbl_frames",    32'(fd_total - f0), 32'(vec[v].exp_fd));
      chk("tbl_frame_idx", 32'(frame_idx), 32'(vec[v].exp_idx));
      chk("tbl_error",     32'(error), 32'd0);
      for (int k = 0; k < 3; k++) begin
        byte_exp = (k == 0) ? vec[v].sh[23:16] : (k == 1) ? vec[v].sh[15:8] : vec[v].sh[7:0];
        chk("tbl_wr_addr", 32'(wa[(we0 + k) % 256]), 32'(k + 1));
        chk("tbl_wr_data", 32'(wd[(we0 + k) % 256]), 32'(byte_exp));
      end
      chk("tbl_wr_consec1", 32'(wcyc[(we0 + 1) % 256] - wcyc[we0 % 256]), 32'd1);
      chk("tbl_wr_consec2", 32'(wcyc[(we0 + 2) % 256] - wcyc[(we0 + 1) % 256]), 32'd1);
      for (int t = 1; t < vec[v].exp_trig; t++)
        chk("tbl_gap", 32'(gap_log[(t0 + t) % 256] >= int'(vec[v].gp)), 32'd1);
      repeat (3) @(negedge clk);
    end

    // start while busy is ignored
    we0 = we_total; t0 = trig_total; f0 = fd_total;
    shutter = 24'h55AA55; frames = 8'd2; gap = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_trigger(1'b1, 20);
    wait_trigger(1'b0, 20);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_busy_low("restart", 5000);
    repeat (2) @(negedge clk);
    chk("restart_writes",   32'(we_total - we0), 32'd3);
    chk("restart_triggers", 32'(trig_total - t0), 32'd2);
    chk("restart_idx",      32'(frame_idx), 32'd2);

    // start and abort together in IDLE
    we0 = we_total;
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("sa_busy0", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("sa_busy5",  32'(busy), 32'd0);
    chk("sa_writes", 32'(we_total - we0), 32'd0);

    // abort during configuration kills the write the same edge
    frames = 8'd1; gap = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("acfg_we_before", 32'(reg_we), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("acfg_we",   32'(reg_we), 32'd0);
    chk("acfg_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("acfg_no_trig", 32'(trigger), 32'd0);

    // abort during trigger
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_trigger(1'b1, 20);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("atrig_trigger", 32'(trigger), 32'd0);
    chk("atrig_busy",    32'(busy), 32'd0);
    repeat (40) @(negedge clk);

    // abort mid-READ after two lines
    vact_lines = 2;
    f0 = fd_total;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_trigger(1'b1, 20);
    wait_trigger(1'b0, 20);
    repeat (30) @(negedge clk);
    chk("aread_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("aread_busy",    32'(busy), 32'd0);
    chk("aread_trigger", 32'(trigger), 32'd0);
    repeat (5) @(negedge clk);
    chk("aread_no_done", 32'(fd_total - f0), 32'd0);
    chk("aread_idx",     32'(frame_idx), 32'd0);
    vact_lines = LINES;

    // continuous mode: 257 frames, frame_idx wraps to 1
    f0 = fd_total;
    frames = 8'd0; gap = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (((fd_total - f0) < 257) && (n < 20000)) begin
      @(negedge clk);
      n++;
    end
    chk("cont_frames", 32'(fd_total - f0), 32'd257);
    chk("cont_idx",    32'(frame_idx), 32'd1);
    chk("cont_busy",   32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("cont_busy_hold", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("cont_abort_busy", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    chk("cont_abort_idx",  32'(frame_idx), 32'd1);
    chk("cont_abort_idle", 32'(busy), 32'd0);

    // watchdog with vact held low; WAITV entered after edge 7
    vact_en = 1'b0;
    frames = 8'd1; gap = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (106) @(negedge clk);
    chk("wd_err_early",  32'(error), 32'd0);
    chk("wd_busy_early", 32'(busy), 32'd1);
    @(negedge clk);
`ifdef TIM_CAPTURE_SEQ_WATCHDOG_EN
    chk("wd_error", 32'(error), 32'd1);
    chk("wd_idle",  32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("wd_sticky", 32'(error), 32'd1);
    vact_en = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("wd_clear", 32'(error), 32'd0);
    wait_busy_low("wd_rerun", 500);
    chk("wd_rerun_idx", 32'(frame_idx), 32'd1);
`else
    chk("nowd_error", 32'(error), 32'd0);
    chk("nowd_busy",  32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("nowd_abort", 32'(busy), 32'd0);
    vact_en = 1'b1;
`endif
    repeat (5) @(negedge clk);

    // asynchronous reset in the middle of a register write
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("arst_we_before", 32'(reg_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",   32'(reg_we), 32'd0);
    chk("arst_a",    32'(reg_a), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_stay_idle", 32'(busy), 32'd0);
    chk("arst_no_trig",   32'(trigger), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
